rvv_backend_uop_queue: RTL
==========================

# rvv_backend_uop_queue

Uop Queue between the RVV decode stage and dispatch. It accepts up to 4 decoded uops per cycle from decode control and presents up to 2 uops per cycle to dispatch, in program order. It exports the full and almost-full status that decode control uses to decide when it may push, which is only when at least 4 entries are free.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of 2, at least 8.
- PTR_W, $clog2(DEPTH): pointer width. Count width is PTR_W+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (trap/kill).
- push  in  [`NUM_DE_UOP-1:0]  per-slot write strobe from decode control; must be a low-order thermometer code (0000/0001/0011/0111/1111).
- datain  in  UOP_QUEUE_t [`NUM_DE_UOP-1:0]  uops to write; slot 0 is oldest.
- fifo_full_uq2de  out  1  count == DEPTH.
- fifo_almost_full_uq2de  out  [`NUM_DE_UOP-1:1]  bit k set when exactly k entries are free.
- uop_valid_uq2dp  out  [1:0]  bit j set when count > j.
- uop_uq2dp  out  UOP_QUEUE_t [1:0]  entries at rptr and rptr+1 (mod DEPTH).
- uop_ready_dp2uq  in  [1:0]  dispatch accepts slot j.
- uq_empty  out  1  count == 0.
- overflow_err  out  1  sticky protocol-error flag.

## Operation
- Storage is a circular buffer of DEPTH UOP_QUEUE_t entries, with registers wptr, rptr and count.
- Push count npush is the number of set bits in push. When the thermometer rule holds, slot i writes mem[wptr+i] for i < npush, and wptr advances by npush, modulo DEPTH.
- Pop handshake is prefix only:
  - pop0 = valid0 & ready0.
  - pop1 = pop0 & valid1 & ready1.
  - npop = pop0 + pop1. ready1 without pop0 pops nothing.
  - rptr advances by npop, modulo DEPTH.
- Count update: count_next = count + npush_eff − npop, computed at PTR_W+1 bits.
- Free space: free = DEPTH − count.
  - fifo_full_uq2de = (free == 0).
  - fifo_almost_full_uq2de[k] = (free == k) for k = 1..3.
  - With these encodings, decode sees "ready" exactly when free ≥ 4.
- Overflow protection:
  - If npush > free + npop, only the first (free + npop) slots are written and overflow_err sets.
  - Pop frees space in the same cycle, so a push into a full queue that coincides with a pop writes up to npop entries.
- A non-thermometer push vector writes nothing and sets overflow_err.
- overflow_err clears only on rst.
- Flush:
  - wptr = rptr = count = 0.
  - push and pop in the same cycle are ignored.
  - overflow_err is unaffected.
  - Flush takes priority over all other events.
- No reads of stale data: uop_uq2dp[j] is don't-care when uop_valid_uq2dp[j] = 0. The bench checks data only when valid is set.

## Timing
- Reset (rst high, asynchronous): wptr = rptr = count = 0.
  - Outputs: fifo_full_uq2de = 0, fifo_almost_full_uq2de = 000, uop_valid_uq2dp = 00, uq_empty = 1, overflow_err = 0.
  - Memory contents are not reset.
- All status outputs are decoded from registered count. They reflect a push or pop on the cycle after the edge that commits it.
- Push-to-dispatch latency is 1 cycle: a uop written at edge N is visible with valid on the uop_uq2dp outputs after edge N.
- No bypass from datain to uop_uq2dp when the queue is empty.
- uop_uq2dp and uop_valid_uq2dp are combinational from the registers (memory read at rptr). They must be stable within the cycle.
- Pop is combinational on uop_ready_dp2uq and takes effect at the next edge.
- Pointer wrap: a 4-wide push with wptr = DEPTH−2 writes entries DEPTH−2, DEPTH−1, 0 and 1, and wptr becomes 2.
- Simultaneous push and pop at count = DEPTH−4 with npush = 4 and npop = 2 gives count = DEPTH−2, so fifo_almost_full_uq2de[2] = 1.
- Reset asserted mid-operation clears state on assertion. The first push is accepted on the first edge after rst deasserts.

## Test plan
- Reset, then push 1111 with uops A,B,C,D -> next cycle uop_valid_uq2dp = 11 carrying A,B, and uq_empty = 0. With ready = 11 on two consecutive cycles -> A,B then C,D appear, then uq_empty = 1.
- With DEPTH = 16, push 1111 four times and hold ready = 00 -> fifo_full_uq2de = 1. Walk down with single pops:
  - free = 1 -> fifo_almost_full_uq2de = 001.
  - free = 2 -> 010.
  - free = 3 -> 100.
  - free = 4 -> 000 and full = 0.
- Wrap: set rptr = wptr = 14 via 14 pushes and 14 pops, then push 1111 (W,X,Y,Z) -> entries 14,15,0,1 are written. Dispatch receives W,X then Y,Z in order.
- Prefix pop: with 3 entries, ready = 10 -> no pop and count stays 3. ready = 01 -> pops 1 and count = 2.
- Illegal push: push 0101 -> nothing written and overflow_err = 1, sticky until rst. Push 1111 at count = 15 with ready = 00 -> one entry written, count = 16, overflow_err = 1.
- Flush with count = 9 together with push 1111 and ready = 11 -> next cycle count = 0, uq_empty = 1, uop_valid_uq2dp = 00. The next push A lands at entry 0 and appears one cycle later.

Source files
------------

// File: rtl/rvv_backend_uop_queue.sv
// Uop queue between RVV decode and dispatch: up to 4 uops in per cycle,
// up to 2 out per cycle in program order, with free-space status for decode.
package rvv_uq_pkg;
  typedef struct packed {
    logic [31:0] insn;
    logic [7:0]  uid;
  } UOP_QUEUE_t;
endpackage

`ifndef NUM_DE_UOP
`define NUM_DE_UOP 4
`endif

module rvv_backend_uop_queue
  import rvv_uq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [`NUM_DE_UOP-1:0]         push,
  input  UOP_QUEUE_t [`NUM_DE_UOP-1:0]   datain,
  output logic                           fifo_full_uq2de,
  output logic [`NUM_DE_UOP-1:1]         fifo_almost_full_uq2de,
  output logic [1:0]                     uop_valid_uq2dp,
  output UOP_QUEUE_t [1:0]               uop_uq2dp,
  input  logic [1:0]                     uop_ready_dp2uq,
  output logic                           uq_empty,
  output logic                           overflow_err
);

  localparam int NDE   = `NUM_DE_UOP;
  localparam int NP_W  = $clog2(NDE + 1);
  localparam int CNT_W = PTR_W + 1;

  UOP_QUEUE_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;

  logic [CNT_W-1:0]       free_s, avail_s;
  logic [NP_W-1:0]        npush_s, npush_eff_s;
  logic [1:0]             npop_s;
  logic                   pop0_s, pop1_s, legal_s;
  logic [NDE-1:0]         we_s;

  // Status and read ports decode straight from registered state.
  always_comb begin
    free_s          = CNT_W'(DEPTH) - count_q;
    fifo_full_uq2de = (free_s == '0);
    for (int k = 1; k < NDE; k++) begin
      fifo_almost_full_uq2de[k] = (free_s == CNT_W'(k));
    end
    uop_valid_uq2dp[0] = (count_q > CNT_W'(0));
    uop_valid_uq2dp[1] = (count_q > CNT_W'(1));
    uq_empty           = (count_q == '0);
    overflow_err       = err_q;
    uop_uq2dp[0]       = mem_q[rptr_q];
    uop_uq2dp[1]       = mem_q[rptr_q + PTR_W'(1)];
  end

  // Prefix pop, push legality/clipping and next-state computation.
  always_comb begin
    pop0_s  = uop_valid_uq2dp[0] & uop_ready_dp2uq[0];
    pop1_s  = pop0_s & uop_valid_uq2dp[1] & uop_ready_dp2uq[1];
    npop_s  = {1'b0, pop0_s} + {1'b0, pop1_s};
    npush_s = '0;
    for (int i = 0; i < NDE; i++) begin
      npush_s = npush_s + NP_W'(push[i]);
    end
    legal_s = (((push + NDE'(1)) & push) == '0);
    // Space freed by this cycle's pop is reusable by this cycle's push.
    avail_s = free_s + CNT_W'(npop_s);
    err_d   = err_q;
    if (flush) begin
      npush_eff_s = '0;
    end else if (!legal_s) begin
      npush_eff_s = '0;
      err_d       = 1'b1;
    end else if (CNT_W'(npush_s) > avail_s) begin
      npush_eff_s = avail_s[NP_W-1:0];
      err_d       = 1'b1;
    end else begin
      npush_eff_s = npush_s;
    end
    for (int i = 0; i < NDE; i++) begin
      we_s[i] = (npush_eff_s > NP_W'(i));
    end
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PTR_W'(npush_eff_s);
      rptr_d  = rptr_q + PTR_W'(npop_s);
      count_d = count_q + CNT_W'(npush_eff_s) - CNT_W'(npop_s);
    end
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NDE; i++) begin
      if (we_s[i]) begin
        mem_q[wptr_q + PTR_W'(i)] <= datain[i];
      end
    end
  end

endmodule
